ysyx_22050039_ifu: RTL

Instruction fetch unit. It is the producer of the 32-bit instruction word consumed by the decoder.
- Owns the PC register.
- Issues word-aligned reads to instruction memory over a valid/ready request bus plus a response strobe.
- Presents each fetched instruction with its PC to the decoder under a valid/ready handshake.
- Takes PC redirects (jal, jalr, taken branches) from the execute stage.

---
 rtl/ysyx_22050039_ifu.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ysyx_22050039_ifu.sv
// rtl/ysyx_22050039_ifu.sv - instruction fetch unit: PC, one-outstanding memory read FSM, decoder handshake
// Optional misaligned-PC fault state enabled by defining YSYX_22050039_IFU_ALIGN_CHECK_EN.
module ysyx_22050039_ifu #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                req_valid_o,
  output logic [XLEN-1:0]     req_addr_o,
  input  logic                req_ready_i,
  input  logic                resp_valid_i,
  input  logic [XLEN-1:0]     resp_data_i,
  output logic [INST_LEN-1:0] inst_o,
  output logic [XLEN-1:0]     inst_pc_o,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  input  logic                redirect_valid_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic [XLEN-1:0]     fetch_count_o
`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
  ,
  output logic                fetch_fault_o
`endif
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
    ,
    S_FAULT = 2'd3
`endif
  } state_e;

  state_e              state_q;
  logic [XLEN-1:0]     pc_q;
  logic                flush_q;
  logic [INST_LEN-1:0] inst_q;
  logic [XLEN-1:0]     inst_pc_q;
  logic                inst_valid_q;
  logic [XLEN-1:0]     fetch_count_q;

  logic [XLEN-1:0]     pc_seq_d;
  logic [INST_LEN-1:0] word_d;
  logic                pc_misaligned;
  logic                req_fire;

`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
  logic fault_q;
  assign pc_misaligned = |pc_q[1:0];
  assign fetch_fault_o = fault_q;
`else
  assign pc_misaligned = 1'b0;
`endif

  assign pc_seq_d    = pc_q + XLEN'(4);
  assign word_d      = pc_q[2] ? resp_data_i[2*INST_LEN-1:INST_LEN] : resp_data_i[INST_LEN-1:0];
  assign req_valid_o = !rst_i && (state_q == S_REQ) && !pc_misaligned;
  assign req_addr_o  = {pc_q[XLEN-1:3], 3'b000};
  assign req_fire    = req_valid_o && req_ready_i;

  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;
  assign inst_valid_o  = inst_valid_q;
  assign fetch_count_o = fetch_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      fetch_count_q <= '0;
`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          if (redirect_valid_i) pc_q <= redirect_pc_i;
          // An issued request whose PC was redirected in the same cycle must be drained, not used.
          if (req_fire) begin
            state_q <= S_WAIT;
            flush_q <= redirect_valid_i;
          end
`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
          else if (pc_misaligned && !redirect_valid_i) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end
`endif
        end
        S_WAIT: begin
          if (redirect_valid_i) pc_q <= redirect_pc_i;
          if (resp_valid_i) begin
            flush_q <= 1'b0;
            if (flush_q || redirect_valid_i) begin
              state_q <= S_REQ;
            end else begin
              inst_q       <= word_d;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              state_q      <= S_HOLD;
            end
          end else if (redirect_valid_i) begin
            flush_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (inst_ready_i) fetch_count_q <= fetch_count_q + XLEN'(1);
          if (inst_ready_i || redirect_valid_i) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_REQ;
          end
          if (redirect_valid_i) pc_q <= redirect_pc_i;
          else if (inst_ready_i) pc_q <= pc_seq_d;
        end
`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
        S_FAULT: begin
          if (redirect_valid_i) begin
            pc_q    <= redirect_pc_i;
            fault_q <= 1'b0;
            state_q <= S_REQ;
          end
        end
`endif
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule
